tx_scheduler: RTL

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler_pkg.sv | 50 +++++
 rtl/tx_scheduler_sync_fifo.sv | 53 +++++
 rtl/tx_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, report
// framing constants and the ASCII digit/report-byte helpers.
package tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    localparam int         RPT_LEN     = 10;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Out-of-range field values are deliberately not clamped (63 -> "63").
    function automatic logic [7:0] tens_digit(input logic [5:0] v);
        return ASCII_ZERO + 8'(v / 6'd10);
    endfunction

    function automatic logic [7:0] ones_digit(input logic [5:0] v);
        return ASCII_ZERO + 8'(v % 6'd10);
    endfunction

    // Byte idx of "HH:MM:SS\r\n" built from the snapshotted time.
    function automatic logic [7:0] rpt_char(
        input logic [3:0] idx,
        input logic [4:0] h,
        input logic [5:0] m,
        input logic [5:0] s
    );
        logic [7:0] c;
        case (idx)
            4'd0:    c = tens_digit({1'b0, h});
            4'd1:    c = ones_digit({1'b0, h});
            4'd2:    c = ASCII_COLON;
            4'd3:    c = tens_digit(m);
            4'd4:    c = ones_digit(m);
            4'd5:    c = ASCII_COLON;
            4'd6:    c = tens_digit(s);
            4'd7:    c = ones_digit(s);
            4'd8:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tx_scheduler_sync_fifo.sv
// Small synchronous FIFO holding received bytes awaiting echo; the head word
// is presented combinationally so it can be loaded in the same cycle it pops.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Shares one UART transmitter between byte echo and a 10-byte "HH:MM:SS\r\n"
// time report, arbitrating round-robin per whole message.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter bit ECHO_EN    = 1'b1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rpt_req,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       rpt_busy,
    output logic       echo_drop
);

    tx_state_e  state_q, state_d;
    logic       pending_q, pending_d;
    logic [3:0] idx_q, idx_d;
    logic [4:0] hour_snap_q, hour_snap_d;
    logic [5:0] min_snap_q, min_snap_d;
    logic [5:0] sec_snap_q, sec_snap_d;
    logic       last_rpt_q, last_rpt_d;
    logic       cur_rpt_q, cur_rpt_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       echo_drop_q, echo_drop_d;

    logic       fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic       echo_ok, rpt_mid, grant_rpt, grant_echo;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (fifo_wr),
        .wr_data (rx_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_wr = ECHO_EN && rx_done;
    assign echo_ok = ECHO_EN && !fifo_empty;
    // A partly sent report keeps the grant so its bytes are never interleaved.
    assign rpt_mid    = pending_q && (idx_q != 4'd0);
    assign grant_rpt  = rpt_mid || (pending_q && (!echo_ok || !last_rpt_q));
    assign grant_echo = !grant_rpt && echo_ok;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        idx_d       = idx_q;
        hour_snap_d = hour_snap_q;
        min_snap_d  = min_snap_q;
        sec_snap_d  = sec_snap_q;
        last_rpt_d  = last_rpt_q;
        cur_rpt_d   = cur_rpt_q;
        tx_data_d   = tx_data_q;
        fifo_rd     = 1'b0;

        if (rpt_req && !pending_q) begin
            pending_d   = 1'b1;
            hour_snap_d = hour;
            min_snap_d  = min;
            sec_snap_d  = sec;
        end

        case (state_q)
            ST_IDLE: begin
                if (!tx_busy && (grant_rpt || grant_echo)) begin
                    state_d    = ST_START;
                    cur_rpt_d  = grant_rpt;
                    last_rpt_d = grant_rpt;
                    if (grant_rpt) begin
                        tx_data_d = rpt_char(idx_q, hour_snap_q, min_snap_q, sec_snap_q);
                        idx_d     = (idx_q == 4'(RPT_LEN - 1)) ? 4'd0 : idx_q + 4'd1;
                    end else begin
                        fifo_rd   = 1'b1;
                        tx_data_d = fifo_head;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                    // Index has wrapped only after the final report byte went out.
                    if (cur_rpt_q && (idx_q == 4'd0)) begin
                        pending_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        echo_drop_d = fifo_wr && fifo_full && !fifo_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            idx_q       <= 4'd0;
            hour_snap_q <= 5'd0;
            min_snap_q  <= 6'd0;
            sec_snap_q  <= 6'd0;
            last_rpt_q  <= 1'b1;
            cur_rpt_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            echo_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            hour_snap_q <= hour_snap_d;
            min_snap_q  <= min_snap_d;
            sec_snap_q  <= sec_snap_d;
            last_rpt_q  <= last_rpt_d;
            cur_rpt_q   <= cur_rpt_d;
            tx_data_q   <= tx_data_d;
            echo_drop_q <= echo_drop_d;
        end
    end

    assign tx_start  = (state_q == ST_START);
    assign tx_data   = tx_data_q;
    assign rpt_busy  = pending_q;
    assign echo_drop = echo_drop_q;

endmodule
